// File: rtl/zx_kbd_matrix.sv
// -----------------------------------------------------------------------------
// zx_kbd_matrix
//
// Purpose:
//   Translates the PS/2 Set-2 scancode stream from the ps2_keyboard receiver
//   into the ZX Spectrum 8x5 half-row key matrix, and answers the ULA port FEh
//   keyboard read on D. Also owns the F1 help-screen toggle for the video unit.
//
// Parameters:
//   SKIP_E1       bytes discarded after an E1 prefix (Pause key sequence)
//
// Ports:
//   CLOCK_50      in   1   system clock, the only clock
//   RESET_N       in   1   synchronous active-low reset
//   ps2_data      in   8   received scancode byte, valid with ps2_data_clk
//   ps2_data_clk  in   1   one-cycle byte strobe
//   A             in  16   Z80 address bus, A[15:8] selects half-rows (active-low)
//   D             out  8   port FEh read value {3'b111, keys[4:0]}, active-low
//   f1_screen     out  1   help-screen enable, toggles on each fresh F1 make
//
// Configuration:
//   ZXKBD_EXTKEYS_EN  when defined, cursor keys, backspace, right Ctrl and
//                     keypad Enter are mapped through a 7-bit composite
//                     register; otherwise E0-prefixed codes and 66 are ignored.
// -----------------------------------------------------------------------------
module zx_kbd_matrix #(
    parameter int SKIP_E1 = 7
) (
    input  logic        CLOCK_50,
    input  logic        RESET_N,
    input  logic [7:0]  ps2_data,
    input  logic        ps2_data_clk,
    input  logic [15:0] A,
    output logic [7:0]  D,
    output logic        f1_screen
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_BRK  = 3'd1;
    localparam logic [2:0] ST_EXT  = 3'd2;
    localparam logic [2:0] ST_EBRK = 3'd3;
    localparam logic [2:0] ST_SKIP = 3'd4;

    localparam logic [7:0] SKIP_LOAD = 8'(SKIP_E1);

    // Base scancode lookup: {valid, row[2:0], col[2:0]}.
    function automatic logic [6:0] map_code(input logic [7:0] code);
        case (code)
            8'h12, 8'h59: map_code = {1'b1, 3'd0, 3'd0};
            8'h1A: map_code = {1'b1, 3'd0, 3'd1};
            8'h22: map_code = {1'b1, 3'd0, 3'd2};
            8'h21: map_code = {1'b1, 3'd0, 3'd3};
            8'h2A: map_code = {1'b1, 3'd0, 3'd4};
            8'h1C: map_code = {1'b1, 3'd1, 3'd0};
            8'h1B: map_code = {1'b1, 3'd1, 3'd1};
            8'h23: map_code = {1'b1, 3'd1, 3'd2};
            8'h2B: map_code = {1'b1, 3'd1, 3'd3};
            8'h34: map_code = {1'b1, 3'd1, 3'd4};
            8'h15: map_code = {1'b1, 3'd2, 3'd0};
            8'h1D: map_code = {1'b1, 3'd2, 3'd1};
            8'h24: map_code = {1'b1, 3'd2, 3'd2};
            8'h2D: map_code = {1'b1, 3'd2, 3'd3};
            8'h2C: map_code = {1'b1, 3'd2, 3'd4};
            8'h16: map_code = {1'b1, 3'd3, 3'd0};
            8'h1E: map_code = {1'b1, 3'd3, 3'd1};
            8'h26: map_code = {1'b1, 3'd3, 3'd2};
            8'h25: map_code = {1'b1, 3'd3, 3'd3};
            8'h2E: map_code = {1'b1, 3'd3, 3'd4};
            8'h45: map_code = {1'b1, 3'd4, 3'd0};
            8'h46: map_code = {1'b1, 3'd4, 3'd1};
            8'h3E: map_code = {1'b1, 3'd4, 3'd2};
            8'h3D: map_code = {1'b1, 3'd4, 3'd3};
            8'h36: map_code = {1'b1, 3'd4, 3'd4};
            8'h4D: map_code = {1'b1, 3'd5, 3'd0};
            8'h44: map_code = {1'b1, 3'd5, 3'd1};
            8'h43: map_code = {1'b1, 3'd5, 3'd2};
            8'h3C: map_code = {1'b1, 3'd5, 3'd3};
            8'h35: map_code = {1'b1, 3'd5, 3'd4};
            8'h5A: map_code = {1'b1, 3'd6, 3'd0};
            8'h4B: map_code = {1'b1, 3'd6, 3'd1};
            8'h42: map_code = {1'b1, 3'd6, 3'd2};
            8'h3B: map_code = {1'b1, 3'd6, 3'd3};
            8'h33: map_code = {1'b1, 3'd6, 3'd4};
            8'h29: map_code = {1'b1, 3'd7, 3'd0};
            8'h14: map_code = {1'b1, 3'd7, 3'd1};
            8'h3A: map_code = {1'b1, 3'd7, 3'd2};
            8'h31: map_code = {1'b1, 3'd7, 3'd3};
            8'h32: map_code = {1'b1, 3'd7, 3'd4};
            default: map_code = 7'd0;
        endcase
    endfunction

`ifdef ZXKBD_EXTKEYS_EN
    // Composite register bit lookup: {valid, index[2:0]}.
    // Bits 0..4 imply CAPS (left, down, up, right, backspace),
    // bit 5 is right Ctrl (SYMSHIFT), bit 6 is keypad Enter (ENTER).
    function automatic logic [3:0] comp_code(input logic [7:0] code, input logic ext);
        if (ext) begin
            case (code)
                8'h6B: comp_code = {1'b1, 3'd0};
                8'h72: comp_code = {1'b1, 3'd1};
                8'h75: comp_code = {1'b1, 3'd2};
                8'h74: comp_code = {1'b1, 3'd3};
                8'h14: comp_code = {1'b1, 3'd5};
                8'h5A: comp_code = {1'b1, 3'd6};
                default: comp_code = 4'd0;
            endcase
        end else begin
            case (code)
                8'h66: comp_code = {1'b1, 3'd4};
                default: comp_code = 4'd0;
            endcase
        end
    endfunction

    logic [6:0] r_comp;
    logic [3:0] w_comp_base;
    logic [3:0] w_comp_ext;
    assign w_comp_base = comp_code(ps2_data, 1'b0);
    assign w_comp_ext  = comp_code(ps2_data, 1'b1);
`endif

    logic [7:0][4:0] r_m;
    logic [2:0]      r_state;
    logic [7:0]      r_cnt;
    logic            r_f1;
    logic            r_f1_held;

    logic [6:0]      w_map;
    logic            w_valid;
    logic [2:0]      w_row;
    logic [2:0]      w_col;
    logic [7:0][4:0] w_eff;
    logic [4:0]      w_or;
    logic            w_unused_a;

    assign w_map      = map_code(ps2_data);
    assign w_valid    = w_map[6];
    assign w_row      = w_map[5:3];
    assign w_col      = w_map[2:0];
    assign w_unused_a = ^A[7:0];
    assign f1_screen  = r_f1;

    // Scancode parser: prefix FSM, matrix updates and F1 toggle.
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            r_m       <= '0;
            r_state   <= ST_IDLE;
            r_cnt     <= 8'd0;
            r_f1      <= 1'b0;
            r_f1_held <= 1'b0;
`ifdef ZXKBD_EXTKEYS_EN
            r_comp    <= 7'd0;
`endif
        end else if (ps2_data_clk) begin
            case (r_state)
                ST_IDLE: begin
                    case (ps2_data)
                        8'hF0: r_state <= ST_BRK;
                        8'hE0: r_state <= ST_EXT;
                        8'hE1: begin
                            if (SKIP_LOAD != 8'd0) begin
                                r_state <= ST_SKIP;
                                r_cnt   <= SKIP_LOAD;
                            end
                        end
                        8'hAA, 8'hFA, 8'hEE: begin
                        end
                        8'h00, 8'hFF: begin
                            r_m <= '0;
`ifdef ZXKBD_EXTKEYS_EN
                            r_comp <= 7'd0;
`endif
                        end
                        8'h05: begin
                            // Only a fresh press toggles; typematic repeats keep f1_held set.
                            if (!r_f1_held) begin
                                r_f1      <= ~r_f1;
                                r_f1_held <= 1'b1;
                            end
                        end
                        default: begin
                            if (w_valid) begin
                                r_m[w_row][w_col] <= 1'b1;
                            end
`ifdef ZXKBD_EXTKEYS_EN
                            if (w_comp_base[3]) begin
                                r_comp[w_comp_base[2:0]] <= 1'b1;
                            end
`endif
                        end
                    endcase
                end
                ST_BRK: begin
                    r_state <= ST_IDLE;
                    if (ps2_data == 8'h05) begin
                        r_f1_held <= 1'b0;
                    end
                    if (w_valid) begin
                        r_m[w_row][w_col] <= 1'b0;
                    end
`ifdef ZXKBD_EXTKEYS_EN
                    if (w_comp_base[3]) begin
                        r_comp[w_comp_base[2:0]] <= 1'b0;
                    end
`endif
                end
                ST_EXT: begin
                    if (ps2_data == 8'hF0) begin
                        r_state <= ST_EBRK;
                    end else begin
                        r_state <= ST_IDLE;
`ifdef ZXKBD_EXTKEYS_EN
                        if (w_comp_ext[3]) begin
                            r_comp[w_comp_ext[2:0]] <= 1'b1;
                        end
`endif
                    end
                end
                ST_EBRK: begin
                    r_state <= ST_IDLE;
`ifdef ZXKBD_EXTKEYS_EN
                    if (w_comp_ext[3]) begin
                        r_comp[w_comp_ext[2:0]] <= 1'b0;
                    end
`endif
                end
                ST_SKIP: begin
                    r_cnt <= r_cnt - 8'd1;
                    if (r_cnt <= 8'd1) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Effective matrix: real keys ORed with whatever composites imply.
    always_comb begin
        w_eff = r_m;
`ifdef ZXKBD_EXTKEYS_EN
        w_eff[0][0] = r_m[0][0] | (|r_comp[4:0]);  // CAPS
        w_eff[3][4] = r_m[3][4] | r_comp[0];       // 5 (left)
        w_eff[4][4] = r_m[4][4] | r_comp[1];       // 6 (down)
        w_eff[4][3] = r_m[4][3] | r_comp[2];       // 7 (up)
        w_eff[4][2] = r_m[4][2] | r_comp[3];       // 8 (right)
        w_eff[4][0] = r_m[4][0] | r_comp[4];       // 0 (backspace)
        w_eff[7][1] = r_m[7][1] | r_comp[5];       // SYMSHIFT
        w_eff[6][0] = r_m[6][0] | r_comp[6];       // ENTER
`endif
    end

    // Port FEh read: OR every half-row whose address line is low.
    always_comb begin
        w_or = 5'b00000;
        for (int r = 0; r < 8; r++) begin
            if (!A[8+r]) begin
                w_or = w_or | w_eff[r];
            end else begin
                w_or = w_or;
            end
        end
        D = {3'b111, ~w_or};
    end

endmodule

// File: tb/tb_zx_kbd_matrix.sv
module tb_zx_kbd_matrix;

    logic        CLOCK_50;
    logic        RESET_N;
    logic [7:0]  ps2_data;
    logic        ps2_data_clk;
    logic [15:0] A;
    logic [7:0]  D;
    logic        f1_screen;

    int tests_run = 0;
    int tests_failed = 0;

    zx_kbd_matrix #(.SKIP_E1(7)) dut (
        .CLOCK_50     (CLOCK_50),
        .RESET_N      (RESET_N),
        .ps2_data     (ps2_data),
        .ps2_data_clk (ps2_data_clk),
        .A            (A),
        .D            (D),
        .f1_screen    (f1_screen)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic send_byte(input logic [7:0] b);
        @(negedge CLOCK_50);
        ps2_data     = b;
        ps2_data_clk = 1'b1;
        @(negedge CLOCK_50);
        ps2_data_clk = 1'b0;
        ps2_data     = 8'h00;
    endtask

    task automatic rd(input logic [15:0] addr, output logic [7:0] val);
        A = addr;
        #1;
        val = D;
    endtask

    task automatic do_reset();
        @(negedge CLOCK_50);
        RESET_N = 1'b0;
        @(negedge CLOCK_50);
        RESET_N = 1'b1;
    endtask

    task automatic test_reset();
        logic [7:0] v;
        do_reset();
        rd(16'h00FE, v);
        tests_run++;
        if (v !== 8'hFF) begin
            $display("FAIL reset_D got %h want %h", v, 8'hFF);
            tests_failed++;
        end
        tests_run++;
        if (f1_screen !== 1'b0) begin
            $display("FAIL reset_f1 got %b want %b", f1_screen, 1'b0);
            tests_failed++;
        end
    endtask

    task automatic test_press_a();
        logic [7:0] v;
        send_byte(8'h1C);
        rd(16'hFDFE, v);
        tests_run++;
        if (v !== 8'hFE) begin
            $display("FAIL press_a got %h want %h", v, 8'hFE);
            tests_failed++;
        end
        send_byte(8'hF0);
        send_byte(8'h1C);
        rd(16'hFDFE, v);
        tests_run++;
        if (v !== 8'hFF) begin
            $display("FAIL release_a got %h want %h", v, 8'hFF);
            tests_failed++;
        end
    endtask

    task automatic test_rows();
        logic [7:0]  codes [11];
        logic [15:0] addrs [11];
        logic [7:0]  exps  [11];
        logic [7:0]  v;
        codes = '{8'h1A, 8'h34, 8'h2C, 8'h16, 8'h36, 8'h35, 8'h33, 8'h32, 8'h5A, 8'h14, 8'h59};
        addrs = '{16'hFEFE, 16'hFDFE, 16'hFBFE, 16'hF7FE, 16'hEFFE, 16'hDFFE,
                  16'hBFFE, 16'h7FFE, 16'hBFFE, 16'h7FFE, 16'hFEFE};
        exps  = '{8'hFD, 8'hEF, 8'hEF, 8'hFE, 8'hEF, 8'hEF, 8'hEF, 8'hEF, 8'hFE, 8'hFD, 8'hFE};
        for (int i = 0; i < 11; i++) begin
            send_byte(codes[i]);
            rd(addrs[i], v);
            tests_run++;
            if (v !== exps[i]) begin
                $display("FAIL row_make code %h got %h want %h", codes[i], v, exps[i]);
                tests_failed++;
            end
            send_byte(8'hF0);
            send_byte(codes[i]);
            rd(16'h00FE, v);
            tests_run++;
            if (v !== 8'hFF) begin
                $display("FAIL row_break code %h got %h want %h", codes[i], v, 8'hFF);
                tests_failed++;
            end
        end
    endtask

    task automatic test_multi_row();
        logic [7:0] v;
        send_byte(8'h15);
        send_byte(8'h4D);
        rd(16'h00FE, v);
        tests_run++;
        if (v !== 8'hFE) begin
            $display("FAIL multi_all got %h want %h", v, 8'hFE);
            tests_failed++;
        end
        rd(16'hFFFE, v);
        tests_run++;
        if (v !== 8'hFF) begin
            $display("FAIL multi_none got %h want %h", v, 8'hFF);
            tests_failed++;
        end
        rd(16'hDFFE, v);
        tests_run++;
        if (v !== 8'hFE) begin
            $display("FAIL multi_row5 got %h want %h", v, 8'hFE);
            tests_failed++;
        end
        send_byte(8'hF0);
        send_byte(8'h15);
        send_byte(8'hF0);
        send_byte(8'h4D);
        rd(16'h00FE, v);
        tests_run++;
        if (v !== 8'hFF) begin
            $display("FAIL multi_release got %h want %h", v, 8'hFF);
            tests_failed++;
        end
    endtask

    task automatic test_typematic();
        logic [7:0] v;
        send_byte(8'h1C);
        send_byte(8'h1C);
        send_byte(8'h1C);
        rd(16'hFDFE, v);
        tests_run++;
        if (v !== 8'hFE) begin
            $display("FAIL typematic_held got %h want %h", v, 8'hFE);
            tests_failed++;
        end
        send_byte(8'hF0);
        send_byte(8'h1C);
        rd(16'hFDFE, v);
        tests_run++;
        if (v !== 8'hFF) begin
            $display("FAIL typematic_release got %h want %h", v, 8'hFF);
            tests_failed++;
        end
    endtask

    task automatic test_f1();
        logic [7:0] v;
        send_byte(8'h05);
        tests_run++;
        if (f1_screen !== 1'b1) begin
            $display("FAIL f1_first got %b want %b", f1_screen, 1'b1);
            tests_failed++;
        end
        send_byte(8'h05);
        send_byte(8'h05);
        tests_run++;
        if (f1_screen !== 1'b1) begin
            $display("FAIL f1_repeat got %b want %b", f1_screen, 1'b1);
            tests_failed++;
        end
        send_byte(8'hF0);
        send_byte(8'h05);
        tests_run++;
        if (f1_screen !== 1'b1) begin
            $display("FAIL f1_break got %b want %b", f1_screen, 1'b1);
            tests_failed++;
        end
        send_byte(8'h05);
        tests_run++;
        if (f1_screen !== 1'b0) begin
            $display("FAIL f1_second got %b want %b", f1_screen, 1'b0);
            tests_failed++;
        end
        rd(16'h00FE, v);
        tests_run++;
        if (v !== 8'hFF) begin
            $display("FAIL f1_no_key got %h want %h", v, 8'hFF);
            tests_failed++;
        end
    endtask

    task automatic test_pause();
        logic [7:0] seq [8];
        logic [7:0] v;
        seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        for (int i = 0; i < 8; i++) send_byte(seq[i]);
        rd(16'h00FE, v);
        tests_run++;
        if (v !== 8'hFF) begin
            $display("FAIL pause_matrix got %h want %h", v, 8'hFF);
            tests_failed++;
        end
        send_byte(8'h1C);
        rd(16'hFDFE, v);
        tests_run++;
        if (v !== 8'hFE) begin
            $display("FAIL pause_next got %h want %h", v, 8'hFE);
            tests_failed++;
        end
        send_byte(8'hF0);
        send_byte(8'h1C);
    endtask

    task automatic test_clear();
        logic [7:0] v;
        send_byte(8'h1C);
        send_byte(8'h2C);
        send_byte(8'h00);
        rd(16'h00FE, v);
        tests_run++;
        if (v !== 8'hFF) begin
            $display("FAIL clear_00 got %h want %h", v, 8'hFF);
            tests_failed++;
        end
        send_byte(8'h32);
        send_byte(8'hFF);
        rd(16'h00FE, v);
        tests_run++;
        if (v !== 8'hFF) begin
            $display("FAIL clear_ff got %h want %h", v, 8'hFF);
            tests_failed++;
        end
    endtask

    task automatic test_ignored();
        logic [7:0] v;
        send_byte(8'hAA);
        send_byte(8'hFA);
        send_byte(8'hEE);
        send_byte(8'hE0);
        send_byte(8'h12);
        rd(16'h00FE, v);
        tests_run++;
        if (v !== 8'hFF) begin
            $display("FAIL ignored_codes got %h want %h", v, 8'hFF);
            tests_failed++;
        end
        // Break of an unmapped key must still return the parser to IDLE.
        send_byte(8'hF0);
        send_byte(8'h77);
        send_byte(8'h1C);
        rd(16'hFDFE, v);
        tests_run++;
        if (v !== 8'hFE) begin
            $display("FAIL unmapped_break got %h want %h", v, 8'hFE);
            tests_failed++;
        end
        send_byte(8'hF0);
        send_byte(8'h1C);
    endtask

`ifdef ZXKBD_EXTKEYS_EN
    task automatic test_ext();
        logic [7:0] v;
        send_byte(8'hE0);
        send_byte(8'h6B);
        rd(16'hFEFE, v);
        tests_run++;
        if (v !== 8'hFE) begin
            $display("FAIL left_caps got %h want %h", v, 8'hFE);
            tests_failed++;
        end
        rd(16'hF7FE, v);
        tests_run++;
        if (v !== 8'hEF) begin
            $display("FAIL left_5 got %h want %h", v, 8'hEF);
            tests_failed++;
        end
        send_byte(8'h12);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h6B);
        rd(16'hFEFE, v);
        tests_run++;
        if (v !== 8'hFE) begin
            $display("FAIL caps_kept got %h want %h", v, 8'hFE);
            tests_failed++;
        end
        send_byte(8'hF0);
        send_byte(8'h12);
        rd(16'hFEFE, v);
        tests_run++;
        if (v !== 8'hFF) begin
            $display("FAIL caps_released got %h want %h", v, 8'hFF);
            tests_failed++;
        end
        send_byte(8'h66);
        rd(16'hEFFE, v);
        tests_run++;
        if (v !== 8'hFE) begin
            $display("FAIL backspace_0 got %h want %h", v, 8'hFE);
            tests_failed++;
        end
        send_byte(8'hE0);
        send_byte(8'h14);
        rd(16'h7FFE, v);
        tests_run++;
        if (v !== 8'hFD) begin
            $display("FAIL rctrl_sym got %h want %h", v, 8'hFD);
            tests_failed++;
        end
        send_byte(8'hF0);
        send_byte(8'h66);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h14);
        rd(16'h00FE, v);
        tests_run++;
        if (v !== 8'hFF) begin
            $display("FAIL ext_release got %h want %h", v, 8'hFF);
            tests_failed++;
        end
    endtask
`else
    task automatic test_ext();
        logic [7:0] v;
        send_byte(8'hE0);
        send_byte(8'h6B);
        send_byte(8'h66);
        rd(16'h00FE, v);
        tests_run++;
        if (v !== 8'hFF) begin
            $display("FAIL ext_disabled got %h want %h", v, 8'hFF);
            tests_failed++;
        end
        send_byte(8'hE0);
        send_byte(8'h14);
        rd(16'h7FFE, v);
        tests_run++;
        if (v !== 8'hFF) begin
            $display("FAIL rctrl_disabled got %h want %h", v, 8'hFF);
            tests_failed++;
        end
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h1C);
        send_byte(8'h1B);
        rd(16'hFDFE, v);
        tests_run++;
        if (v !== 8'hFD) begin
            $display("FAIL ebrk_return got %h want %h", v, 8'hFD);
            tests_failed++;
        end
        send_byte(8'hF0);
        send_byte(8'h1B);
    endtask
`endif

    task automatic test_back_to_back();
        logic [7:0] v;
        @(negedge CLOCK_50);
        ps2_data     = 8'h1C;
        ps2_data_clk = 1'b1;
        @(negedge CLOCK_50);
        ps2_data     = 8'h1B;
        @(negedge CLOCK_50);
        ps2_data_clk = 1'b0;
        rd(16'hFDFE, v);
        tests_run++;
        if (v !== 8'hFC) begin
            $display("FAIL b2b_make got %h want %h", v, 8'hFC);
            tests_failed++;
        end
        @(negedge CLOCK_50);
        ps2_data     = 8'hF0;
        ps2_data_clk = 1'b1;
        @(negedge CLOCK_50);
        ps2_data     = 8'h1C;
        @(negedge CLOCK_50);
        ps2_data_clk = 1'b0;
        rd(16'hFDFE, v);
        tests_run++;
        if (v !== 8'hFD) begin
            $display("FAIL b2b_break got %h want %h", v, 8'hFD);
            tests_failed++;
        end
        send_byte(8'hF0);
        send_byte(8'h1B);
    endtask

    task automatic test_reset_priority();
        logic [7:0] v;
        @(negedge CLOCK_50);
        RESET_N      = 1'b0;
        ps2_data     = 8'h1C;
        ps2_data_clk = 1'b1;
        @(negedge CLOCK_50);
        RESET_N      = 1'b1;
        ps2_data_clk = 1'b0;
        rd(16'hFDFE, v);
        tests_run++;
        if (v !== 8'hFF) begin
            $display("FAIL reset_drops_strobe got %h want %h", v, 8'hFF);
            tests_failed++;
        end
    endtask

    task automatic test_reset_midprefix();
        logic [7:0] v;
        send_byte(8'h05);
        tests_run++;
        if (f1_screen !== 1'b1) begin
            $display("FAIL midprefix_f1_set got %b want %b", f1_screen, 1'b1);
            tests_failed++;
        end
        send_byte(8'hE0);
        do_reset();
        send_byte(8'h1C);
        rd(16'hFDFE, v);
        tests_run++;
        if (v !== 8'hFE) begin
            $display("FAIL midprefix_a got %h want %h", v, 8'hFE);
            tests_failed++;
        end
        tests_run++;
        if (f1_screen !== 1'b0) begin
            $display("FAIL midprefix_f1 got %b want %b", f1_screen, 1'b0);
            tests_failed++;
        end
        rd(16'h02FE, v);
        tests_run++;
        if (v !== 8'hFF) begin
            $display("FAIL midprefix_others got %h want %h", v, 8'hFF);
            tests_failed++;
        end
        send_byte(8'hF0);
        send_byte(8'h1C);
        do_reset();
        send_byte(8'hF0);
        do_reset();
        send_byte(8'h1C);
        rd(16'hFDFE, v);
        tests_run++;
        if (v !== 8'hFE) begin
            $display("FAIL midbreak_a got %h want %h", v, 8'hFE);
            tests_failed++;
        end
    endtask

    initial begin
        RESET_N      = 1'b0;
        ps2_data     = 8'h00;
        ps2_data_clk = 1'b0;
        A            = 16'hFFFE;
        repeat (2) @(negedge CLOCK_50);
        RESET_N = 1'b1;
        test_reset();
        test_press_a();
        test_rows();
        test_multi_row();
        test_typematic();
        test_f1();
        test_pause();
        test_clear();
        test_ignored();
        test_ext();
        test_back_to_back();
        test_reset_priority();
        test_reset_midprefix();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/zx_kbd_matrix.md
# zx_kbd_matrix

Converts the PS/2 Set-2 scancode stream into the ZX Spectrum 8×5 key matrix. Serves the ULA keyboard read on port FEh. It sits between the `ps2_keyboard` receiver, which is upstream, and the top-level Z80 data-bus mux, which is downstream. It also owns the F1 help-screen toggle consumed by the video unit.

## Interface
Parameters:
- `SKIP_E1` (default 7): number of bytes discarded after an `E1` prefix (the Pause key sequence).

Ports:
- `CLOCK_50`  in  1  system clock; the only clock.
- `RESET_N`  in  1  synchronous, active-low reset, sampled on the `CLOCK_50` rising edge.
- `ps2_data`  in  8  received scancode byte; valid while `ps2_data_clk`=1.
- `ps2_data_clk`  in  1  one-cycle strobe, synchronous to `CLOCK_50`.
- `A`  in  16  Z80 address bus; A[15:8] selects the half-rows.
- `D`  out  8  port FEh read value: {3'b111, keys[4:0]}, active-low.
- `f1_screen`  out  1  help-screen enable; toggles on each F1 make.

## Operation
- Internal matrix `m[7:0][4:0]`: 1 means pressed. It is set on a make code and cleared on a break code.
- Half-rows, listed bit0..bit4:
  - Row 0 (A8): CAPS (12, 59), Z 1A, X 22, C 21, V 2A
  - Row 1 (A9): A 1C, S 1B, D 23, F 2B, G 34
  - Row 2 (A10): Q 15, W 1D, E 24, R 2D, T 2C
  - Row 3 (A11): 1 16, 2 1E, 3 26, 4 25, 5 2E
  - Row 4 (A12): 0 45, 9 46, 8 3E, 7 3D, 6 36
  - Row 5 (A13): P 4D, O 44, I 43, U 3C, Y 35
  - Row 6 (A14): ENTER 5A, L 4B, K 42, J 3B, H 33
  - Row 7 (A15): SPACE 29, SYMSHIFT 14, M 3A, N 31, B 32
- Parser FSM:
  - IDLE:
    - `F0` → BRK
    - `E0` → EXT
    - `E1` → SKIP (counter loaded with SKIP_E1)
    - `AA`, `FA`, `EE` → ignored
    - `00` or `FF` → clear the whole matrix
    - any other byte → make, stay in IDLE
  - BRK: any byte → break, → IDLE.
  - EXT:
    - `F0` → EBRK
    - any other byte → extended make, → IDLE
  - EBRK: any byte → extended break, → IDLE.
  - SKIP: decrement on each strobe; → IDLE when the count reaches 0.
- Unmapped codes in any state are ignored and do not affect the FSM.
- `E0 12` (fake shift) is ignored.
- `D` is combinational from `A` and the registered matrix:
  - D[4:0] = ~(OR of `m[r]` over every r with A[8+r]=0).
  - If no row is selected, D[4:0] = 5'b11111.
  - D[7:5] = 3'b111.
- F1 (`05`):
  - Make while the internal `f1_held`=0 → toggle `f1_screen` and set `f1_held`.
  - Break → clear `f1_held`.
  - Typematic repeats therefore do not toggle.
- Make of an already-pressed key (typematic) is idempotent.

## Timing
- Strobe at edge N → matrix, FSM and `f1_screen` are updated at edge N+1.
- `D` follows `A` and the matrix combinationally, with no added latency. The Z80 IORQ read window is therefore satisfied.
- Strobes arriving in consecutive cycles are each processed. No backpressure is needed.
- Reset takes priority over a coincident strobe. The strobe byte is dropped.
- Reset values:
  - matrix all 0, so `D` = 8'hFF
  - FSM IDLE, SKIP counter 0
  - `f1_screen` = 0, `f1_held` = 0
  - composite register 0
- Reset in the middle of a prefix sequence discards the prefix. The next byte is decoded from IDLE.

## Configuration
- `ZXKBD_EXTKEYS_EN` defined: composite and extended keys are compiled in, held in a separate 7-bit composite register.
  - CAPS-shifted composites:
    - left `E0 6B` → CAPS+5
    - down `E0 72` → CAPS+6
    - up `E0 75` → CAPS+7
    - right `E0 74` → CAPS+8
    - backspace `66` → CAPS+0
  - Direct extended mappings:
    - `E0 14` (right Ctrl) → SYMSHIFT
    - `E0 5A` (keypad Enter) → ENTER
  - Effective CAPS = real CAPS OR any CAPS-composite held. Releasing one composite does not drop CAPS while another composite or the real CAPS is still held.
  - Effective digit bits are ORed the same way.
- Not defined: every `E0`-prefixed code is parsed and then ignored, and `66` is unmapped.

## Test plan
- Press A, read FDFE: `1C` then A=16'hFDFE → D=8'hFE. Then `F0 1C` → D=8'hFF.
- Multi-row read: Q and P held, A=16'h00FE → D=8'hFE. Same keys, A=16'hFFFE → D=8'hFF.
- Left arrow (EXTKEYS_EN): `E0 6B` → A=16'hFEFE gives 8'hFE and A=16'hF7FE gives 8'hEF. Add `12`, then `E0 F0 6B` → FEFE still 8'hFE. Then `F0 12` → 8'hFF.
- F1 toggle: `05 05 05` → `f1_screen`=1 after the first byte and stays 1. Then `F0 05`, `05` → 0.
- Pause skip: `E1 14 77 E1 F0 14 F0 77` → matrix unchanged, with no SYMSHIFT and no stray key. The next `1C` registers A.
- Reset mid-prefix: `E0`, then RESET_N=0 for 1 cycle, then `1C` → A pressed (FDFE=8'hFE). `f1_screen`=0 and all other rows read 8'hFF.
